sd_dat_block_tx: RTL

Card-side SD DAT0 block transmitter that is the responder end of the host's bit-banged DAT line port. On a start pulse it serialises one data block onto DAT0 in SD 1-bit mode: preamble, start bit, data MSB-first, CRC16 and end bit. Bytes come from a local buffer through a valid/ready handshake. Bits change on falling edges of the host-driven sd_clk, which is sampled in the system clock domain.

---
 rtl/sd_dat_pkg.sv | 19 +
 rtl/sd_crc16_serial.sv | 30 +++
 rtl/sd_dat_block_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT0 block transmitter and its host-side peer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sd_dat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        START,
        DATA,
        CRC,
        END
    } sd_state_t;

    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic        SD_START_BIT = 1'b0;
    localparam logic        SD_END_BIT   = 1'b1;

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CCITT CRC16 (x^16+x^12+x^5+1), initial value zero.
// Latency: crc reflects bit_in one clk after en.
// Backpressure: none; updates only on clk where en=1, clr has priority.
module sd_crc16_serial
    import sd_dat_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic fb;

    assign fb = bit_in ^ crc[15];

    // Shift-and-xor CRC register; feeding bit_in=crc[15] makes it a plain left shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_dat_block_tx.sv
// Card-side DAT0 block sender: preamble, start bit, data MSB-first, CRC16, end bit.
// Latency: line changes 3 clk after each sd_clk falling edge (2-flop sync + edge detect + output reg).
// Backpressure: one-byte prefetch via byte_valid/byte_ready; an empty prefetch at load time aborts the block.
module sd_dat_block_tx
    import sd_dat_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int NAC_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sd_clk,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       dat_out,
    output logic       dat_oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam int PW = $clog2(NAC_CYCLES + 1);

    logic            sd_s1, sd_s2, sd_prev;
    logic            fall_evt;
    sd_state_t       state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      crc_cnt_q, crc_cnt_d;
    logic            end_ph_q, end_ph_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      pf_dat_q, pf_dat_d;
    logic            pf_full_q, pf_full_d;
    logic            dat_out_q, dat_out_d;
    logic            dat_oe_q, dat_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            und_q, und_d;
    logic            hs, load, abort;
    logic            crc_clr, crc_en, crc_bit;
    logic [15:0]     crc;

    assign fall_evt   = sd_prev & ~sd_s2;
    assign byte_ready = busy_q & ~pf_full_q & (fetch_cnt_q < CW'(BLOCK_BYTES));
    assign hs         = byte_valid & byte_ready;

    assign dat_out  = dat_out_q;
    assign dat_oe   = dat_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = und_q;

    sd_crc16_serial u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (crc_clr),
        .en      (crc_en),
        .bit_in  (crc_bit),
        .crc     (crc)
    );

    // Bring the host sd_clk into the clk domain and keep the previous level for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
            sd_prev <= 1'b0;
        end else begin
            sd_s1   <= sd_clk;
            sd_s2   <= sd_s1;
            sd_prev <= sd_s2;
        end
    end

    // Register FSM state, counters, prefetch and the registered line/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            byte_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            bit_q       <= '0;
            crc_cnt_q   <= '0;
            end_ph_q    <= 1'b0;
            shift_q     <= '0;
            pf_dat_q    <= '0;
            pf_full_q   <= 1'b0;
            dat_out_q   <= 1'b1;
            dat_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            byte_cnt_q  <= byte_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            bit_q       <= bit_d;
            crc_cnt_q   <= crc_cnt_d;
            end_ph_q    <= end_ph_d;
            shift_q     <= shift_d;
            pf_dat_q    <= pf_dat_d;
            pf_full_q   <= pf_full_d;
            dat_out_q   <= dat_out_d;
            dat_oe_q    <= dat_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            und_q       <= und_d;
        end
    end

    // Next-state logic: every line action is gated on fall_evt; abort overrides the line drive.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        byte_cnt_d  = byte_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        bit_d       = bit_q;
        crc_cnt_d   = crc_cnt_q;
        end_ph_d    = end_ph_q;
        shift_d     = shift_q;
        pf_dat_d    = pf_dat_q;
        pf_full_d   = pf_full_q;
        dat_out_d   = dat_out_q;
        dat_oe_d    = dat_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        und_d       = 1'b0;
        load        = 1'b0;
        abort       = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = 1'b0;

        case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (start) begin
                    state_d     = PRE;
                    busy_d      = 1'b1;
                    crc_clr     = 1'b1;
                    byte_cnt_d  = '0;
                    fetch_cnt_d = '0;
                    pre_d       = '0;
                end
            end
            PRE: begin
                if (fall_evt) begin
                    dat_oe_d  = 1'b1;
                    dat_out_d = 1'b1;
                    pre_d     = pre_q + PW'(1);
                    if (pre_q == PW'(NAC_CYCLES - 1)) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (fall_evt) begin
                    if (pf_full_q) begin
                        dat_out_d = SD_START_BIT;
                        shift_d   = pf_dat_q;
                        load      = 1'b1;
                        bit_d     = '0;
                        state_d   = DATA;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_evt) begin
                    dat_out_d = shift_q[7];
                    crc_en    = 1'b1;
                    crc_bit   = shift_q[7];
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_d     = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                        if (byte_cnt_q == CW'(BLOCK_BYTES - 1)) begin
                            state_d   = CRC;
                            crc_cnt_d = '0;
                        end else if (pf_full_q) begin
                            shift_d = pf_dat_q;
                            load    = 1'b1;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
            end
            CRC: begin
                // Feeding the CRC its own MSB zeroes the feedback, so the register shifts out unchanged.
                if (fall_evt) begin
                    dat_out_d = crc[15];
                    crc_en    = 1'b1;
                    crc_bit   = crc[15];
                    crc_cnt_d = crc_cnt_q + 4'd1;
                    if (crc_cnt_q == 4'd15) begin
                        state_d  = END;
                        end_ph_d = 1'b0;
                    end
                end
            end
            END: begin
                if (fall_evt) begin
                    if (!end_ph_q) begin
                        dat_out_d = SD_END_BIT;
                        end_ph_d  = 1'b1;
                    end else begin
                        dat_oe_d = 1'b0;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Prefetch: a fetch in the same clk as a load keeps the new byte.
        if (load) begin
            pf_full_d = 1'b0;
        end
        if (hs) begin
            pf_full_d   = 1'b1;
            pf_dat_d    = byte_data;
            fetch_cnt_d = fetch_cnt_q + CW'(1);
        end

        if (abort) begin
            dat_oe_d  = 1'b0;
            dat_out_d = 1'b1;
            und_d     = 1'b1;
            busy_d    = 1'b0;
            pf_full_d = 1'b0;
            state_d   = IDLE;
        end
    end

endmodule
